vc_sync_ni: RTL and testbench

VC_SYNC_NI -- requirements
Module: vc_sync_ni

---
 rtl/vc_sync_ni_pkg.sv | 26 ++
 rtl/sync2.sv | 23 ++
 rtl/vc_sync_ni.sv | 219 +++++++++++++++++++++
 tb/tb_vc_sync_ni.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vc_sync_ni_pkg.sv
// Shared definitions for the 1-of-4 network interface: flit types, FSM states,
// and the rail encode/decode helpers used on both link directions.
package vc_sync_ni_pkg;

    localparam logic [2:0] FT_HEAD = 3'b001;
    localparam logic [2:0] FT_BODY = 3'b010;
    localparam logic [2:0] FT_TAIL = 3'b100;

    typedef enum logic [1:0] {T_IDLE, T_DATA, T_NULL} tx_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ACK, R_WAIT} rx_state_t;

    // 2-bit binary value to a 4-rail chain with exactly one rail raised
    function automatic logic [3:0] bin2chain(input logic [1:0] k);
        return 4'b0001 << k;
    endfunction

    // Inverse of bin2chain; only meaningful for a one-hot chain
    function automatic logic [1:0] chain2bin(input logic [3:0] r);
        return {r[3] | r[2], r[3] | r[1]};
    endfunction

    function automatic logic grp_complete(input logic [3:0] r);
        return $onehot(r);
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a bundle of asynchronous inputs.
module sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] s_p0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_p0 <= '0;
            q    <= '0;
        end else begin
            s_p0 <= d;
            q    <= s_p0;
        end
    end

endmodule

// File: rtl/vc_sync_ni.sv
// Synchronous-to-1-of-4 network interface: credit-based VC injection onto a
// four-phase delay-insensitive link, and a one-entry ejection buffer.
module vc_sync_ni
    import vc_sync_ni_pkg::*;
#(
    parameter int DW     = 32,
    parameter int VCN    = 2,
    parameter int FT     = 3,
    parameter int CDEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic [DW-1:0]        tx_data,
    input  logic [VCN-1:0]       tx_vc,
    input  logic [FT-1:0]        tx_ft,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic [DW-1:0]        rx_data,
    output logic [VCN-1:0]       rx_vc,
    output logic [FT-1:0]        rx_ft,
    output logic [DW/2-1:0]      lo0,
    output logic [DW/2-1:0]      lo1,
    output logic [DW/2-1:0]      lo2,
    output logic [DW/2-1:0]      lo3,
    output logic [FT-1:0]        loft,
    output logic [VCN-1:0]       lovc,
    input  logic                 loa,
    input  logic [VCN-1:0]       lcr,
    input  logic [DW/2-1:0]      li0,
    input  logic [DW/2-1:0]      li1,
    input  logic [DW/2-1:0]      li2,
    input  logic [DW/2-1:0]      li3,
    input  logic [FT-1:0]        lift,
    input  logic [VCN-1:0]       livc,
    output logic                 lia,
    output logic [VCN-1:0]       lcro,
    output logic                 err
);

    localparam int SCN = DW / 2;
    localparam int CW  = $clog2(CDEPTH + 1);
    localparam int SW  = 1 + VCN + 4 * SCN + FT + VCN;
    localparam logic [CW-1:0] CMAX = CW'(CDEPTH);

    logic [SW-1:0]  async_in, sync_q;
    logic           loa_s;
    logic [VCN-1:0] lcr_s, livc_s;
    logic [SCN-1:0] li0_s, li1_s, li2_s, li3_s;
    logic [FT-1:0]  lift_s;

    assign async_in = {loa, lcr, li3, li2, li1, li0, lift, livc};

    sync2 #(.W(SW)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (async_in),
        .q     (sync_q)
    );

    assign {loa_s, lcr_s, li3_s, li2_s, li1_s, li0_s, lift_s, livc_s} = sync_q;

    // ---------------- TX: inject port to 1-of-4 link ----------------
    tx_state_t                tx_st, tx_nx;
    logic                     tx_acc, tx_clr, tx_cr_ok;
    logic [SCN-1:0]           enc0, enc1, enc2, enc3;
    logic [VCN-1:0][CW-1:0]   cred;
    logic [VCN-1:0]           lcr_q, cr_edge, cr_take;

    always_comb begin
        tx_cr_ok = 1'b0;
        for (int v = 0; v < VCN; v++) begin
            if (tx_vc[v] && (cred[v] != '0)) tx_cr_ok = 1'b1;
        end
    end

    assign tx_ready = rst_n && (tx_st == T_IDLE) && $onehot(tx_vc) && tx_cr_ok;
    assign tx_acc   = tx_valid && tx_ready;

    always_comb begin
        enc0 = '0;
        enc1 = '0;
        enc2 = '0;
        enc3 = '0;
        for (int i = 0; i < SCN; i++) begin
            {enc3[i], enc2[i], enc1[i], enc0[i]} = bin2chain(tx_data[2*i +: 2]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tx_st <= T_IDLE;
        else        tx_st <= tx_nx;
    end

    always_comb begin
        tx_nx  = tx_st;
        tx_clr = 1'b0;
        case (tx_st)
            T_IDLE: if (tx_acc) tx_nx = T_DATA;
            T_DATA: if (loa_s) begin
                tx_clr = 1'b1;
                tx_nx  = T_NULL;
            end
            T_NULL: if (!loa_s) tx_nx = T_IDLE;
            default: tx_nx = T_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {lo3, lo2, lo1, lo0} <= '0;
            loft <= '0;
            lovc <= '0;
        end else if (tx_acc) begin
            {lo3, lo2, lo1, lo0} <= {enc3, enc2, enc1, enc0};
            loft <= tx_ft;
            lovc <= tx_vc;
        end else if (tx_clr) begin
            {lo3, lo2, lo1, lo0} <= '0;
            loft <= '0;
            lovc <= '0;
        end
    end

    // A returned credit and a spent credit on the same VC cancel out
    assign cr_edge = lcr_s ^ lcr_q;
    assign cr_take = {VCN{tx_acc}} & tx_vc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lcr_q <= '0;
            err   <= 1'b0;
            for (int v = 0; v < VCN; v++) cred[v] <= CMAX;
        end else begin
            lcr_q <= lcr_s;
            for (int v = 0; v < VCN; v++) begin
                if (cr_edge[v] && !cr_take[v]) begin
                    if (cred[v] == CMAX) err <= 1'b1;
                    else                 cred[v] <= cred[v] + CW'(1);
                end else if (!cr_edge[v] && cr_take[v]) begin
                    cred[v] <= cred[v] - CW'(1);
                end
            end
        end
    end

    // ---------------- RX: 1-of-4 link to eject port ----------------
    rx_state_t      rx_st, rx_nx;
    logic           rx_cap, rx_rel, rx_cmp, rx_zero, rx_grp_ok, buf_full;
    logic [3:0]     rx_grp;
    logic [DW-1:0]  rx_dec;

    always_comb begin
        rx_dec    = '0;
        rx_grp    = '0;
        rx_grp_ok = 1'b1;
        for (int i = 0; i < SCN; i++) begin
            rx_grp = {li3_s[i], li2_s[i], li1_s[i], li0_s[i]};
            if (!grp_complete(rx_grp)) rx_grp_ok = 1'b0;
            rx_dec[2*i +: 2] = chain2bin(rx_grp);
        end
    end

    assign rx_cmp  = rx_grp_ok && $onehot(lift_s) && $onehot(livc_s);
    assign rx_zero = ~|{li3_s, li2_s, li1_s, li0_s, lift_s, livc_s};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rx_st <= R_IDLE;
        else        rx_st <= rx_nx;
    end

    always_comb begin
        rx_nx  = rx_st;
        rx_cap = 1'b0;
        rx_rel = 1'b0;
        case (rx_st)
            R_IDLE: if (!buf_full && rx_cmp) begin
                rx_cap = 1'b1;
                rx_nx  = R_ACK;
            end
            R_ACK: if (rx_zero) begin
                rx_rel = 1'b1;
                rx_nx  = R_WAIT;
            end
            R_WAIT: if (!buf_full) rx_nx = R_IDLE;
            default: rx_nx = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lia      <= 1'b0;
            buf_full <= 1'b0;
            lcro     <= '0;
        end else begin
            if (rx_cap)      lia <= 1'b1;
            else if (rx_rel) lia <= 1'b0;
            if (rx_cap) begin
                buf_full <= 1'b1;
            end else if (buf_full && rx_ready) begin
                buf_full <= 1'b0;
                lcro     <= lcro ^ rx_vc;
            end
        end
    end

    // Payload register carries no reset; rx_valid qualifies it
    always_ff @(posedge clk) begin
        if (rx_cap) begin
            rx_data <= rx_dec;
            rx_vc   <= livc_s;
            rx_ft   <= lift_s;
        end
    end

    assign rx_valid = buf_full;

endmodule

// File: tb/tb_vc_sync_ni.sv
// Directed bench for vc_sync_ni with a router-side link model and scoreboards.
module tb_vc_sync_ni;

    localparam int DW = 32, VCN = 2, FT = 3, SCN = 16;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           tx_valid, tx_ready, rx_valid, rx_ready;
    logic [DW-1:0]  tx_data, rx_data;
    logic [VCN-1:0] tx_vc, rx_vc, lovc, lcr, livc, lcro;
    logic [FT-1:0]  tx_ft, rx_ft, loft, lift;
    logic [SCN-1:0] lo0, lo1, lo2, lo3, li0, li1, li2, li3;
    logic           loa, lia, err;

    typedef struct packed {
        logic [SCN-1:0] l3, l2, l1, l0;
        logic [FT-1:0]  ft;
        logic [VCN-1:0] vc;
    } txexp_t;

    typedef struct packed {
        logic [DW-1:0]  d;
        logic [VCN-1:0] vc;
        logic [FT-1:0]  ft;
    } rxexp_t;

    txexp_t txq[$];
    rxexp_t rxq[$];
    int checks = 0;
    int errors = 0;

    vc_sync_ni dut (
        .clk(clk), .rst_n(rst_n),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data), .tx_vc(tx_vc), .tx_ft(tx_ft),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data), .rx_vc(rx_vc), .rx_ft(rx_ft),
        .lo0(lo0), .lo1(lo1), .lo2(lo2), .lo3(lo3), .loft(loft), .lovc(lovc), .loa(loa),
        .lcr(lcr),
        .li0(li0), .li1(li1), .li2(li2), .li3(li3), .lift(lift), .livc(livc), .lia(lia),
        .lcro(lcro), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic txexp_t enc_model(input logic [DW-1:0] d, input logic [VCN-1:0] vc,
                                         input logic [FT-1:0] ft);
        txexp_t e;
        e = '0;
        for (int i = 0; i < SCN; i++) begin
            case ({d[2*i+1], d[2*i]})
                2'd0: e.l0[i] = 1'b1;
                2'd1: e.l1[i] = 1'b1;
                2'd2: e.l2[i] = 1'b1;
                default: e.l3[i] = 1'b1;
            endcase
        end
        e.ft = ft;
        e.vc = vc;
        return e;
    endfunction

    task automatic tx_send(input logic [DW-1:0] d, input logic [VCN-1:0] vc, input logic [FT-1:0] ft);
        int n = 0;
        tx_data = d; tx_vc = vc; tx_ft = ft; tx_valid = 1'b1;
        while (tx_ready !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        chk("tx_ready_wait", {63'd0, tx_ready}, 64'd1);
        txq.push_back(enc_model(d, vc, ft));
        step();
        tx_valid = 1'b0;
    endtask

    task automatic tx_ack();
        txexp_t e;
        int n = 0;
        e = txq.pop_front();
        chk("lo0", lo0, e.l0);
        chk("lo1", lo1, e.l1);
        chk("lo2", lo2, e.l2);
        chk("lo3", lo3, e.l3);
        chk("loft", loft, e.ft);
        chk("lovc", lovc, e.vc);
        loa = 1'b1;
        while ({lo3, lo2, lo1, lo0, loft, lovc} != '0 && n < 20) begin
            step();
            n++;
        end
        chk("tx_null", {lo3, lo2, lo1, lo0, loft, lovc} == '0, 64'd1);
        loa = 1'b0;
        step(4);
    endtask

    task automatic credit_ret(input int v);
        lcr[v] = ~lcr[v];
        step(4);
    endtask

    task automatic set_li(input logic [DW-1:0] d, input logic [VCN-1:0] vc, input logic [FT-1:0] ft);
        txexp_t e;
        e = enc_model(d, vc, ft);
        li0 = e.l0; li1 = e.l1; li2 = e.l2; li3 = e.l3; lift = ft; livc = vc;
    endtask

    task automatic wait_lia(input logic lvl);
        int n = 0;
        while (lia !== lvl && n < 20) begin
            step();
            n++;
        end
        chk("lia_level", {63'd0, lia}, {63'd0, lvl});
    endtask

    task automatic rx_check();
        rxexp_t e;
        e = rxq.pop_front();
        chk("rx_valid", {63'd0, rx_valid}, 64'd1);
        chk("rx_data", rx_data, e.d);
        chk("rx_vc", rx_vc, e.vc);
        chk("rx_ft", rx_ft, e.ft);
    endtask

    initial begin
        logic [VCN-1:0] exp_lcro;
        rst_n = 1'b0; tx_valid = 1'b1; tx_data = '0; tx_vc = 2'b01; tx_ft = 3'b001;
        rx_ready = 1'b0; loa = 1'b0; lcr = '0;
        li0 = '0; li1 = '0; li2 = '0; li3 = '0; lift = '0; livc = '0;
        step(3);
        chk("rst_tx_ready", {63'd0, tx_ready}, 64'd0);
        chk("rst_rx_valid", {63'd0, rx_valid}, 64'd0);
        chk("rst_lia", {63'd0, lia}, 64'd0);
        chk("rst_lcro", lcro, 64'd0);
        chk("rst_err", {63'd0, err}, 64'd0);
        chk("rst_lo", {lo3, lo2, lo1, lo0, loft, lovc} == '0, 64'd1);
        chk("rst_cred0", dut.cred[0], 64'd4);
        chk("rst_cred1", dut.cred[1], 64'd4);
        tx_valid = 1'b0;
        rst_n = 1'b1;
        step(2);

        // Encoding of 0x1B on VC0 as a head flit
        tx_send(32'h1B, 2'b01, 3'b001);
        chk("enc_lo0", lo0, 64'hFFF8);
        chk("enc_lo1", lo1, 64'h0004);
        chk("enc_lo2", lo2, 64'h0002);
        chk("enc_lo3", lo3, 64'h0001);
        chk("cred0_after1", dut.cred[0], 64'd3);
        tx_ack();
        credit_ret(0);
        chk("cred0_restored", dut.cred[0], 64'd4);

        // Exhaust VC0 credits, then a fifth flit must wait for a return
        for (int k = 0; k < 4; k++) begin
            tx_send($urandom, 2'b01, 3'b010);
            tx_ack();
        end
        chk("cred0_empty", dut.cred[0], 64'd0);
        tx_data = 32'hA5A5_5A5A; tx_vc = 2'b01; tx_ft = 3'b100; tx_valid = 1'b1;
        step(5);
        chk("blocked_no_credit", {63'd0, tx_ready}, 64'd0);
        lcr[0] = ~lcr[0];
        tx_send(32'hA5A5_5A5A, 2'b01, 3'b100);
        tx_ack();
        chk("cred0_empty_again", dut.cred[0], 64'd0);

        // Credit return landing on the same edge as an accept
        credit_ret(0);
        credit_ret(0);
        chk("cred0_two", dut.cred[0], 64'd2);
        lcr[0] = ~lcr[0];
        step(2);
        tx_data = 32'h0F0F_3C3C; tx_vc = 2'b01; tx_ft = 3'b010; tx_valid = 1'b1;
        chk("same_cycle_ready", {63'd0, tx_ready}, 64'd1);
        txq.push_back(enc_model(tx_data, tx_vc, tx_ft));
        step();
        tx_valid = 1'b0;
        chk("same_cycle_cred0", dut.cred[0], 64'd2);
        tx_ack();
        chk("same_cycle_cred0_late", dut.cred[0], 64'd2);

        // Overflow on a full VC1 counter
        chk("pre_ovf_err", {63'd0, err}, 64'd0);
        credit_ret(1);
        chk("ovf_err", {63'd0, err}, 64'd1);
        chk("ovf_cred1", dut.cred[1], 64'd4);
        step(3);
        chk("err_sticky", {63'd0, err}, 64'd1);

        // Ejection with back-pressure and a second flit held un-acked
        exp_lcro = '0;
        set_li(32'hDEAD_BEEF, 2'b10, 3'b100);
        rxq.push_back('{d: 32'hDEAD_BEEF, vc: 2'b10, ft: 3'b100});
        step();
        chk("rx_no_bypass", {63'd0, rx_valid}, 64'd0);
        wait_lia(1'b1);
        rx_check();
        set_li('0, '0, '0);
        li0 = '0;
        wait_lia(1'b0);
        set_li(32'h1234_5678, 2'b01, 3'b010);
        rxq.push_back('{d: 32'h1234_5678, vc: 2'b01, ft: 3'b010});
        step(8);
        chk("rx_held_unacked", {63'd0, lia}, 64'd0);
        chk("rx_buf_kept", rx_data, 64'hDEAD_BEEF);
        rx_ready = 1'b1;
        step();
        rx_ready = 1'b0;
        exp_lcro[1] = ~exp_lcro[1];
        chk("lcro_vc1", lcro, exp_lcro);
        chk("rx_freed", {63'd0, rx_valid}, 64'd0);
        wait_lia(1'b1);
        rx_check();
        set_li('0, '0, '0);
        li0 = '0;
        wait_lia(1'b0);
        rx_ready = 1'b1;
        step();
        rx_ready = 1'b0;
        exp_lcro[0] = ~exp_lcro[0];
        chk("lcro_vc0", lcro, exp_lcro);

        // Reset while a flit sits on the link in T_DATA
        tx_send(32'hCAFE_F00D, 2'b10, 3'b001);
        chk("cred1_spent", dut.cred[1], 64'd3);
        #2;
        rst_n = 1'b0; lcr = '0; loa = 1'b0;
        #1;
        chk("mid_rst_lo", {lo3, lo2, lo1, lo0, loft, lovc} == '0, 64'd1);
        chk("mid_rst_cred1", dut.cred[1], 64'd4);
        chk("mid_rst_cred0", dut.cred[0], 64'd4);
        chk("mid_rst_err", {63'd0, err}, 64'd0);
        chk("mid_rst_lcro", lcro, 64'd0);
        void'(txq.pop_front());
        step();
        rst_n = 1'b1;
        step(6);
        chk("post_rst_cred0", dut.cred[0], 64'd4);
        chk("post_rst_cred1", dut.cred[1], 64'd4);
        chk("post_rst_err", {63'd0, err}, 64'd0);
        tx_send(32'h8001_7FFE, 2'b10, 3'b100);
        tx_ack();
        chk("post_rst_cred1_used", dut.cred[1], 64'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
